aes_pipe_sched: RTL and testbench

Issue scheduler and result buffer for the fully pipelined AES-128 encryption core. It shares the core between two requesters using round-robin arbitration. Each accepted block travels through the core with a valid/requester-ID tag, and the result is captured into an output FIFO. A credit rule guarantees that the core's stall-free pipeline never overruns the FIFO, even under downstream backpressure. It sits between the requester-side bus adapters and the AES core.

---
 rtl/aes_sched_pkg.sv | 21 ++
 rtl/aes_sched_fifo.sv | 69 ++++++
 rtl/aes_pipe_sched.sv | 131 +++++++++++++
 tb/tb_aes_pipe_sched.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and defaults for the AES pipeline issue scheduler.
// A result-buffer entry packs the requester id above the ciphertext.
package aes_sched_pkg;

    localparam int BLK_W         = 128;
    localparam int LAT_DEFAULT   = 11;
    localparam int DEPTH_DEFAULT = 16;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    function automatic logic [BLK_W:0] pack_entry(input logic [BLK_W-1:0] data,
                                                  input req_id_t id);
        return {id, data};
    endfunction

endpackage

// File: rtl/aes_sched_fifo.sv
// In-order result FIFO with registered outputs; a pushed entry becomes visible
// on the edge after it is written. occ counts every stored entry, including the one on display.
module aes_sched_fifo
    import aes_sched_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int W    = BLK_W + 1,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] occ
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // The output register only sees entries already in memory before this edge.
    always_comb begin
        pop         = out_valid_q && out_ready;
        wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d       = occ_q + CW'(push) - CW'(pop);
        out_valid_d = (occ_q - CW'(pop)) != '0;
        out_data_d  = out_valid_d ? mem_q[rd_ptr_d] : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign occ       = occ_q;

endmodule

// File: rtl/aes_pipe_sched.sv
// Round-robin issue scheduler and credit-guarded result buffer for the AES-128 core.
// Optional performance counters are enabled with `define AES_SCHED_PERF_EN.
module aes_pipe_sched
    import aes_sched_pkg::*;
#(
    parameter int LAT   = LAT_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [BLK_W-1:0] req0_data,
    input  logic [BLK_W-1:0] req0_key,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [BLK_W-1:0] req1_data,
    input  logic [BLK_W-1:0] req1_key,
    output logic [BLK_W-1:0] core_data_in,
    output logic [BLK_W-1:0] core_key,
    input  logic [BLK_W-1:0] core_data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output req_id_t          out_id
`ifdef AES_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    logic             run_q, run_d;
    logic             last_q, last_d;
    logic [BLK_W-1:0] data_q, data_d;
    logic [BLK_W-1:0] key_q, key_d;
    tag_t             tag_q [LAT+1];
    tag_t             tag_d [LAT+1];
    logic [CW-1:0]    inflight_q, inflight_d;
    logic [CW-1:0]    fifo_occ;
    logic [CW:0]      credit_sum;
    logic             credit_ok;
    logic             accept0, accept1, accept;
    tag_t             exit_tag;
    logic [BLK_W:0]   fifo_out;

    // tag_q[0] rides with the issue register; tag_q[LAT] lines up with core_data_out.
    always_comb begin
        run_d      = 1'b1;
        credit_sum = {1'b0, inflight_q} + {1'b0, fifo_occ};
        credit_ok  = credit_sum < (CW+1)'(DEPTH);
        req0_ready = run_q && credit_ok && (!req1_valid || last_q);
        req1_ready = run_q && credit_ok && (!req0_valid || !last_q);
        accept0    = req0_valid && req0_ready;
        accept1    = req1_valid && req1_ready;
        accept     = accept0 || accept1;
        last_d     = accept1 ? 1'b1 : (accept0 ? 1'b0 : last_q);
        data_d     = accept1 ? req1_data : (accept0 ? req0_data : '0);
        key_d      = accept1 ? req1_key  : (accept0 ? req0_key  : '0);
        tag_d[0].valid = accept;
        tag_d[0].id    = accept1;
        for (int i = 1; i <= LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        exit_tag   = tag_q[LAT];
        inflight_d = inflight_q + CW'(accept) - CW'(exit_tag.valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            last_q     <= 1'b1;
            data_q     <= '0;
            key_q      <= '0;
            inflight_q <= '0;
            for (int i = 0; i <= LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            run_q      <= run_d;
            last_q     <= last_d;
            data_q     <= data_d;
            key_q      <= key_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    assign core_data_in = data_q;
    assign core_key     = key_q;

    aes_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (exit_tag.valid),
        .push_data (pack_entry(core_data_out, exit_tag.id)),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (fifo_out),
        .occ       (fifo_occ)
    );

    assign out_data = fifo_out[BLK_W-1:0];
    assign out_id   = fifo_out[BLK_W];

`ifdef AES_SCHED_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issued_d = perf_issued_q + 32'(accept);
        perf_stall_d  = perf_stall_q + 32'((req0_valid || req1_valid) && !credit_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_aes_pipe_sched.sv
// Randomized self-checking bench for aes_pipe_sched with a behavioural AES core stand-in
// and a transaction-level scoreboard (outstanding blocks, visibility times, round-robin rule).
module tb_aes_pipe_sched;
    import aes_sched_pkg::*;

    localparam int LAT   = 11;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         v0 = 1'b0, v1 = 1'b0, ordy = 1'b0;
    logic [127:0] d0 = '0, k0 = '0, d1 = '0, k1 = '0;
    logic         req0_ready, req1_ready, out_valid;
    logic [127:0] core_data_in, core_key, core_data_out, out_data;
    req_id_t      out_id;
`ifdef AES_SCHED_PERF_EN
    logic [31:0]  perf_issued, perf_stall;
`endif

    always #5 clk = ~clk;

    aes_pipe_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid    (v0),
        .req0_ready    (req0_ready),
        .req0_data     (d0),
        .req0_key      (k0),
        .req1_valid    (v1),
        .req1_ready    (req1_ready),
        .req1_data     (d1),
        .req1_key      (k1),
        .core_data_in  (core_data_in),
        .core_key      (core_key),
        .core_data_out (core_data_out),
        .out_valid     (out_valid),
        .out_ready     (ordy),
        .out_data      (out_data),
        .out_id        (out_id)
`ifdef AES_SCHED_PERF_EN
        ,
        .perf_issued   (perf_issued),
        .perf_stall    (perf_stall)
`endif
    );

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] w;
        w = {v, v} << n;
        return w[15:8];
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s [16];
        logic [7:0] k [16];
        logic [7:0] t [16];
        logic [7:0] rcon, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127-8*i -: 8];
            k[i] = key[127-8*i -: 8];
            s[i] = s[i] ^ k[i];
        end
        rcon = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            a0 = k[13]; a1 = k[14]; a2 = k[15]; a3 = k[12];
            k[0] = k[0] ^ sbox[a0] ^ rcon;
            k[1] = k[1] ^ sbox[a1];
            k[2] = k[2] ^ sbox[a2];
            k[3] = k[3] ^ sbox[a3];
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            rcon = xtime(rcon);
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = s[row + 4*((c + row) % 4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r != 10) begin
                    s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                    s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Core stand-in: LAT-deep stall-free pipeline.
    logic [127:0] core_pipe [LAT];
    always @(posedge clk) begin
        core_pipe[0] <= aes_encrypt(core_data_in, core_key);
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_data_out = core_pipe[LAT-1];

    // ---------------- scoreboard / model state ----------------
    typedef struct {
        logic [127:0] data;
        logic         id;
        int           ready_at;
    } exp_t;

    exp_t         sb [$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    bit           last_m = 1'b1;
    bit           use_fips = 1'b0;
    logic [127:0] exp_core_data = '0, exp_core_key = '0;
    int           acc_total = 0, stall_total = 0;
    int           dut_acc = 0, dut_pops = 0;
    int           fips_acc_cyc = -1000, first_valid_cyc = -1;
    logic [127:0] first_valid_data = '0;
    logic         first_valid_id = 1'b1;

    task automatic checkOutput(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int p0, input int p1, input int pr);
        v0   = ($urandom_range(0, 99) < p0);
        v1   = ($urandom_range(0, 99) < p1);
        ordy = ($urandom_range(0, 99) < pr);
        d0 = {$urandom, $urandom, $urandom, $urandom};
        k0 = {$urandom, $urandom, $urandom, $urandom};
        d1 = {$urandom, $urandom, $urandom, $urandom};
        k1 = {$urandom, $urandom, $urandom, $urandom};
        if (use_fips) begin
            d0 = 128'h00112233445566778899aabbccddeeff;
            k0 = 128'h000102030405060708090a0b0c0d0e0f;
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit later, then advance the model.
    task automatic step(input int p0, input int p1, input int pr);
        bit   er0, er1, eov, a0, a1;
        int   pushed;
        exp_t e;
        @(negedge clk);
        applyStimulus(p0, p1, pr);
        #1;
        er0 = (sb.size() < DEPTH) && (!v1 || last_m);
        er1 = (sb.size() < DEPTH) && (!v0 || !last_m);
        eov = (sb.size() > 0) && (cyc >= sb[0].ready_at);
        checkOutput("req0_ready", req0_ready, er0);
        checkOutput("req1_ready", req1_ready, er1);
        checkOutput("out_valid", out_valid, eov);
        if (eov) begin
            checkOutput("out_data", out_data, sb[0].data);
            checkOutput("out_id", out_id, sb[0].id);
        end
        checkOutput("core_data_in", core_data_in, exp_core_data);
        checkOutput("core_key", core_key, exp_core_key);
        pushed = 0;
        foreach (sb[i]) if (cyc >= sb[i].ready_at - 1) pushed++;
        checkOutput("fifo_occ", dut.fifo_occ, pushed);
        checkOutput("occ_le_depth", dut.fifo_occ <= DEPTH, 1);
        if (out_valid && first_valid_cyc < 0) begin
            first_valid_cyc  = cyc;
            first_valid_data = out_data;
            first_valid_id   = out_id;
        end
        if ((v0 && req0_ready) || (v1 && req1_ready)) dut_acc++;
        if (out_valid && ordy) dut_pops++;
        a0 = v0 && er0;
        a1 = v1 && er1;
        if ((v0 || v1) && sb.size() >= DEPTH) stall_total++;
        if (eov && ordy) void'(sb.pop_front());
        exp_core_data = '0;
        exp_core_key  = '0;
        if (a0 || a1) begin
            e.data     = a1 ? aes_encrypt(d1, k1) : aes_encrypt(d0, k0);
            e.id       = a1;
            e.ready_at = cyc + LAT + 3;
            sb.push_back(e);
            last_m        = a1;
            exp_core_data = a1 ? d1 : d0;
            exp_core_key  = a1 ? k1 : k0;
            acc_total++;
            if (a0 && use_fips) fips_acc_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; ordy = 1'b0;
        #1;
        checkOutput("rst_req0_ready", req0_ready, 0);
        checkOutput("rst_req1_ready", req1_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_id", out_id, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_core_data_in", core_data_in, 0);
        checkOutput("rst_core_key", core_key, 0);
        checkOutput("rst_fifo_occ", dut.fifo_occ, 0);
        sb.delete();
        last_m = 1'b1;
        exp_core_data = '0;
        exp_core_key  = '0;
        acc_total = 0;
        stall_total = 0;
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("release_req0_ready", req0_ready, 0);
        checkOutput("release_req1_ready", req1_ready, 0);
        checkOutput("release_out_valid", out_valid, 0);
        cyc++;
    endtask

`ifdef AES_SCHED_PERF_EN
    task automatic checkPerf();
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0; ordy = 1'b0;
        #1;
        checkOutput("perf_issued", perf_issued, acc_total);
        checkOutput("perf_stall", perf_stall, stall_total);
        exp_core_data = '0;
        exp_core_key  = '0;
        cyc++;
    endtask
`endif

    initial begin
        int base;
        doReset();

        // Known-answer vector and end-to-end latency
        use_fips = 1'b1;
        step(100, 0, 100);
        use_fips = 1'b0;
        repeat (LAT + 6) step(0, 0, 100);
        checkOutput("fips_latency", first_valid_cyc - fips_acc_cyc - 1, LAT + 2);
        checkOutput("fips_data", first_valid_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        checkOutput("fips_id", first_valid_id, 0);

        // Fairness with both requesters streaming; req0 wins the first tie after reset
        doReset();
        base = dut_acc;
        repeat (20) step(100, 100, 100);
        checkOutput("fair_accepts", dut_acc - base, 20);
        repeat (LAT + 5) step(0, 0, 100);

        // Backpressure: exactly DEPTH accepts, then resume
        doReset();
        base = dut_acc;
        repeat (DEPTH + LAT + 10) step(100, 0, 0);
        checkOutput("bp_accepts", dut_acc - base, DEPTH);
        base = dut_pops;
        repeat (60) step(100, 0, 100);
        checkOutput("bp_resume_pops", dut_pops - base >= DEPTH, 1);
`ifdef AES_SCHED_PERF_EN
        checkPerf();
`endif

        // Full FIFO with out_ready toggling every cycle
        repeat (40) step(100, 100, 0);
        for (int i = 0; i < 60; i++) step(100, 100, (i % 2) ? 100 : 0);

        // Random traffic
        repeat (400) step(60, 60, 70);

        // Reset with blocks in flight
        repeat (40) step(0, 0, 100);
        repeat (5) step(100, 0, 100);
        doReset();
        repeat (LAT + 2) step(0, 0, 100);
        base = dut_pops;
        step(100, 0, 100);
        repeat (LAT + 4) step(0, 0, 100);
        checkOutput("post_reset_pops", dut_pops - base, 1);

        repeat (LAT + 5) step(0, 0, 100);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
